// File: rtl/usb_dbg_pkg.sv
// rtl/usb_dbg_pkg.sv - shared types, constants and helpers for the USB debug status path
package usb_dbg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_PUSH = 3'd3,
        ST_GAP  = 3'd4
    } pump_state_e;

    localparam logic [7:0] ASCII_FF = 8'h0C;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((64'd1 << r) < 64'(value)) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/usb_byte_fifo.sv
// rtl/usb_byte_fifo.sv - first-word-fall-through byte FIFO with async active-low reset
module usb_byte_fifo
    import usb_dbg_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign do_pop  = pop_i && !empty_o;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/usb_status_pump.sv
// rtl/usb_status_pump.sv - paces annunciator frame fetches into a byte FIFO drained by the UART
module usb_status_pump
    import usb_dbg_pkg::*;
#(
    parameter int FRAME_BYTES    = 320,
    parameter int REFRESH_CYCLES = 4800000,
    parameter int FIFO_DEPTH     = 4,
    parameter int DV_TIMEOUT     = 7
) (
    input  logic       clk48,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       force_refresh,
    input  logic       clear_err,
    output logic       ann_inc,
    input  logic [7:0] ann_q,
    input  logic       ann_dv,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       frame_done,
    output logic       dv_timeout_err
);

    localparam int CW = clog2(FRAME_BYTES + 1);
    localparam int RW = clog2(REFRESH_CYCLES);
    localparam int TW = clog2(DV_TIMEOUT + 1);
    localparam logic [CW-1:0] FRAME_LEN = CW'(FRAME_BYTES);
    localparam logic [RW-1:0] RFR_LAST  = RW'(REFRESH_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(DV_TIMEOUT - 1);

    pump_state_e   state_q;
    logic [RW-1:0] rfr_q, rfr_d;
    logic          pending_q;
    logic [CW-1:0] count_q;
    logic [TW-1:0] tmr_q;
    logic [7:0]    byte_q;
    logic          ann_inc_q, busy_q, frame_done_q, err_q;
    logic          rfr_wrap, frame_start;
    logic          fifo_full, fifo_empty, fifo_push;

    assign rfr_wrap    = (rfr_q == RFR_LAST);
    assign rfr_d       = rfr_wrap ? '0 : rfr_q + 1'b1;
    assign frame_start = (state_q == ST_IDLE) && enable && pending_q && !fifo_full;
    assign fifo_push   = (state_q == ST_PUSH);

    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            rfr_q     <= '0;
            pending_q <= 1'b0;
        end else begin
            rfr_q <= rfr_d;
            if (rfr_wrap || force_refresh) pending_q <= 1'b1;
            else if (frame_start)          pending_q <= 1'b0;
        end
    end

    // tmr_q counts cycles since the inc strobe; a byte is still accepted on the last allowed cycle.
    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            count_q      <= '0;
            tmr_q        <= '0;
            byte_q       <= '0;
            ann_inc_q    <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            ann_inc_q    <= 1'b0;
            frame_done_q <= 1'b0;
            if (clear_err) err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (frame_start) begin
                        state_q   <= ST_REQ;
                        count_q   <= '0;
                        busy_q    <= 1'b1;
                        ann_inc_q <= 1'b1;
                    end
                end
                ST_REQ: begin
                    state_q <= ST_WAIT;
                    tmr_q   <= TW'(1);
                end
                ST_WAIT: begin
                    if (ann_dv) begin
                        byte_q  <= ann_q;
                        state_q <= ST_PUSH;
                    end else if (tmr_q == TMO_LAST) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        tmr_q <= tmr_q + 1'b1;
                    end
                end
                ST_PUSH: begin
                    count_q <= count_q + 1'b1;
                    if (count_q + 1'b1 == FRAME_LEN) begin
                        frame_done_q <= 1'b1;
                        busy_q       <= 1'b0;
                        state_q      <= ST_IDLE;
                    end else if (!enable) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (!enable) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (!fifo_full) begin
                        state_q   <= ST_REQ;
                        ann_inc_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    usb_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk_i   (clk48),
        .rst_ni  (rst_n),
        .push_i  (fifo_push),
        .wdata_i (byte_q),
        .pop_i   (tx_valid && tx_ready),
        .rdata_o (tx_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign tx_valid       = !fifo_empty;
    assign ann_inc        = ann_inc_q;
    assign busy           = busy_q;
    assign frame_done     = frame_done_q;
    assign dv_timeout_err = err_q;

endmodule
